// File: rtl/audio_minmax_pkg.sv
// ---------------------------------------------------------------------------
// audio_minmax_pkg
// Shared definitions for the audio min/max scheduler:
//   - default sample / address widths and frame length
//   - scheduler FSM state encoding
//   - channel identifier type
// ---------------------------------------------------------------------------
package audio_minmax_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_ADDR_W    = 10;
    localparam int DEF_FRAME_LEN = 100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LAST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } ch_t;

endpackage

// File: rtl/minmax_accum.sv
// ---------------------------------------------------------------------------
// minmax_accum
// Running signed minimum / maximum of a sample stream.
// Ports:
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-low reset
//   first   in   current sample starts a new frame (loads both min and max)
//   valid   in   sample is valid this cycle
//   sample  in   signed sample, DATA_W bits
//   max     out  running signed maximum
//   min     out  running signed minimum
// ---------------------------------------------------------------------------
module minmax_accum
    import audio_minmax_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     first,
    input  logic                     valid,
    input  logic signed [DATA_W-1:0] sample,
    output logic signed [DATA_W-1:0] max,
    output logic signed [DATA_W-1:0] min
);

    // The first sample of a frame seeds both extremes directly, so the
    // previous frame's values never leak into the new one. Strict compares
    // keep the stored value on ties.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            max <= '0;
            min <= '0;
        end else if (valid) begin
            if (first) begin
                max <= sample;
                min <= sample;
            end else begin
                if (sample > max) max <= sample;
                if (sample < min) min <= sample;
            end
        end
    end

endmodule

// File: rtl/audio_minmax_sched.sv
// ---------------------------------------------------------------------------
// audio_minmax_sched
// Round-robin scheduler sharing one min/max engine between two audio
// channels. On a grant it streams FRAME_LEN samples from the sample RAM,
// starting at the granted channel's base address, and reports the frame's
// signed maximum and minimum tagged with the channel ID.
// Ports:
//   clk                 in   rising-edge clock
//   reset               in   asynchronous active-low reset
//   req0, req1          in   channel requests, held until the matching ack
//   base0, base1        in   frame start addresses, sampled on the grant edge
//   ack0, ack1          out  one-cycle grant pulses
//   mem_rd_en           out  sample RAM read strobe
//   mem_addr            out  sample RAM read address
//   mem_rd_data         in   read data, valid one cycle after mem_rd_en
//   busy                out  high from the ack cycle through the done cycle
//   d                   out  one-cycle result-valid pulse
//   done_ch             out  channel of the current result
//   out_max, out_min    out  frame maximum / minimum, held until the next d
// ---------------------------------------------------------------------------
module audio_minmax_sched
    import audio_minmax_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0,
    input  logic                     req1,
    input  logic [ADDR_W-1:0]        base0,
    input  logic [ADDR_W-1:0]        base1,
    output logic                     ack0,
    output logic                     ack1,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic signed [DATA_W-1:0] mem_rd_data,
    output logic                     busy,
    output logic                     d,
    output logic                     done_ch,
    output logic signed [DATA_W-1:0] out_max,
    output logic signed [DATA_W-1:0] out_min
);

    // One extra bit so FRAME_LEN = 2^ADDR_W still fits.
    localparam int              CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [ADDR_W-1:0]   addr, addr_nxt;
    ch_t                 ptr, ptr_nxt;
    ch_t                 ch, ch_nxt;
    ch_t                 grant;

    logic                rd_vld_p1;
    logic                first_p1;

    logic signed [DATA_W-1:0] acc_max, acc_min;
    logic signed [DATA_W-1:0] hold_max, hold_min;
    logic                     hold_ch;

    // ---------------- next-state / arbitration ----------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = addr;
        ptr_nxt   = ptr;
        ch_nxt    = ch;
        grant     = CH0;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the channel not granted last time wins;
                    // a lone request is granted regardless of the pointer.
                    if (req0 && req1) grant = (ptr == CH1) ? CH0 : CH1;
                    else              grant = req0 ? CH0 : CH1;
                    ch_nxt    = grant;
                    ptr_nxt   = grant;
                    addr_nxt  = (grant == CH0) ? base0 : base1;
                    cnt_nxt   = '0;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                // Address wraps modulo 2^ADDR_W by its width.
                addr_nxt = addr + 1'b1;
                cnt_nxt  = cnt + 1'b1;
                if (cnt == LAST_CNT) state_nxt = LAST;
            end
            LAST:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            addr  <= '0;
            ptr   <= CH1;
            ch    <= CH0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            addr  <= addr_nxt;
            ptr   <= ptr_nxt;
            ch    <= ch_nxt;
        end
    end

    // ---------------- stage p1: read data returns ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_vld_p1 <= 1'b0;
            first_p1  <= 1'b0;
        end else begin
            rd_vld_p1 <= (state == FETCH);
            first_p1  <= (state == FETCH) && (cnt == '0);
        end
    end

    minmax_accum #(
        .DATA_W (DATA_W)
    ) u_accum (
        .clk    (clk),
        .reset  (reset),
        .first  (first_p1),
        .valid  (rd_vld_p1),
        .sample (mem_rd_data),
        .max    (acc_max),
        .min    (acc_min)
    );

    // ---------------- result hold ----------------
    // The accumulator keeps running on the next frame, so the reported
    // result is captured at the end of DONE and held until the next d.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_max <= '0;
            hold_min <= '0;
            hold_ch  <= 1'b0;
        end else if (state == DONE) begin
            hold_max <= acc_max;
            hold_min <= acc_min;
            hold_ch  <= ch;
        end
    end

    // Outputs decode from registered state so reset clears them at once.
    assign ack0      = (state == FETCH) && (cnt == '0) && (ch == CH0);
    assign ack1      = (state == FETCH) && (cnt == '0) && (ch == CH1);
    assign mem_rd_en = (state == FETCH);
    assign mem_addr  = addr;
    assign busy      = (state != IDLE);
    assign d         = (state == DONE);
    assign done_ch   = d ? ch      : hold_ch;
    assign out_max   = d ? acc_max : hold_max;
    assign out_min   = d ? acc_min : hold_min;

endmodule

// File: tb/tb_audio_minmax_sched.sv
module tb_audio_minmax_sched;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int FL    = 100;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic                 rst_n = 1'b0;
    logic                 req0 = 1'b0, req1 = 1'b0;
    logic [AW-1:0]        base0 = '0, base1 = '0;
    logic                 ack0, ack1, mem_rd_en, busy, d, done_ch;
    logic [AW-1:0]        mem_addr;
    logic signed [DW-1:0] rd_data;
    logic signed [DW-1:0] out_max, out_min;

    logic signed [DW-1:0] ram [DEPTH];
    always @(posedge clk) if (mem_rd_en) rd_data <= ram[mem_addr];

    audio_minmax_sched #(.DATA_W(DW), .ADDR_W(AW), .FRAME_LEN(FL)) dut (
        .clk(clk), .reset(rst_n),
        .req0(req0), .req1(req1), .base0(base0), .base1(base1),
        .ack0(ack0), .ack1(ack1),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(rd_data),
        .busy(busy), .d(d), .done_ch(done_ch),
        .out_max(out_max), .out_min(out_min)
    );

    // Second instance for the single-sample frame corner case.
    logic               s_req0 = 1'b0, s_req1 = 1'b0;
    logic [3:0]         s_base0 = '0, s_base1 = '0;
    logic               s_ack0, s_ack1, s_rd_en, s_busy, s_d, s_done_ch;
    logic [3:0]         s_addr;
    logic signed [7:0]  s_rd_data;
    logic signed [7:0]  s_max, s_min;
    logic signed [7:0]  sram [16];
    always @(posedge clk) if (s_rd_en) s_rd_data <= sram[s_addr];

    audio_minmax_sched #(.DATA_W(8), .ADDR_W(4), .FRAME_LEN(1)) dut1 (
        .clk(clk), .reset(rst_n),
        .req0(s_req0), .req1(s_req1), .base0(s_base0), .base1(s_base1),
        .ack0(s_ack0), .ack1(s_ack1),
        .mem_rd_en(s_rd_en), .mem_addr(s_addr), .mem_rd_data(s_rd_data),
        .busy(s_busy), .d(s_d), .done_ch(s_done_ch),
        .out_max(s_max), .out_min(s_min)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard of expected frame results, popped on every d.
    typedef struct {
        int                   ch;
        logic signed [DW-1:0] mx;
        logic signed [DW-1:0] mn;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && d === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL d_unexpected: got d=1 expected no result (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("done_ch", done_ch, mon_e.ch);
                check("out_max", out_max, mon_e.mx);
                check("out_min", out_min, mon_e.mn);
            end
        end
    end

    typedef struct {
        string                name;
        int                   ch;
        int                   base;
        int                   pat;
        logic signed [DW-1:0] mx;
        logic signed [DW-1:0] mn;
    } vec_t;
    vec_t vt[5];

    // Background values outside every frame, so over-reads corrupt results.
    task automatic fill_bg();
        for (int a = 0; a < DEPTH; a++) ram[a] = (a % 2 == 1) ? -32'sd10000 : 32'sd10000;
    endtask

    task automatic fill_frame(input int base, input int pat);
        logic signed [DW-1:0] v;
        for (int i = 0; i < FL; i++) begin
            case (pat)
                0:       v = DW'(i - 50);
                1:       v = -32'sd7;
                2:       v = (i == 10) ? 32'sh7FFFFFFF : (i == 50) ? 32'sh80000000 : 32'sd123;
                3:       v = '0;
                default: v = (i == 23) ? 32'sd300 : (i == 24) ? -32'sd300 : 32'sd5;
            endcase
            ram[(base + i) % DEPTH] = v;
        end
    endtask

    task automatic push_exp(input int ch, input logic signed [DW-1:0] mx,
                            input logic signed [DW-1:0] mn);
        exp_t e;
        e.ch = ch; e.mx = mx; e.mn = mn;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input int exp_ch, input int limit, output int t_ack);
        int got;
        got = -1;
        t_ack = -1;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (ack0 === 1'b1) begin got = 0; break; end
            if (ack1 === 1'b1) begin got = 1; break; end
        end
        if (got < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL ack_timeout: got no ack expected ack%0d within %0d cycles", exp_ch, limit);
        end else begin
            t_ack = cyc;
            check("grant_ch", got, exp_ch);
        end
    endtask

    // Called at the cycle-0 negedge of a frame; returns at cycle FL+2.
    task automatic watch_frame(input int ch, input int base);
        check("ack_c0", (ch == 1) ? ack1 : ack0, 1);
        check("ack_other_c0", (ch == 1) ? ack0 : ack1, 0);
        check("busy_c0", busy, 1);
        check("rd_en_c0", mem_rd_en, 1);
        check("addr_c0", mem_addr, base % DEPTH);
        if (ch == 1) req1 = 1'b0; else req0 = 1'b0;
        for (int k = 1; k < FL; k++) begin
            @(negedge clk);
            check("rd_en", mem_rd_en, 1);
            check("addr", mem_addr, (base + k) % DEPTH);
            check("ack_while_busy", ack0 | ack1, 0);
        end
        @(negedge clk);
        check("rd_en_last", mem_rd_en, 0);
        check("d_early", d, 0);
        check("ack_while_busy", ack0 | ack1, 0);
        @(negedge clk);
        check("d_pulse", d, 1);
        check("busy_done", busy, 1);
        check("ack_while_busy", ack0 | ack1, 0);
        @(negedge clk);
        check("busy_idle", busy, 0);
        check("d_idle", d, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack0"}, ack0, 0);
        check({tag, "_ack1"}, ack1, 0);
        check({tag, "_rd_en"}, mem_rd_en, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_d"}, d, 0);
        check({tag, "_done_ch"}, done_ch, 0);
        check({tag, "_max"}, out_max, 0);
        check({tag, "_min"}, out_min, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1;

        for (int i = 0; i < 16; i++) sram[i] = 8'(i * 9 - 100);

        vt[0] = '{"ramp",    0, 0,    0, 32'sd49,         -32'sd50};
        vt[1] = '{"wrap",    1, 1000, 4, 32'sd300,        -32'sd300};
        vt[2] = '{"neg7",    0, 200,  1, -32'sd7,         -32'sd7};
        vt[3] = '{"extreme", 1, 500,  2, 32'sh7FFFFFFF,   32'sh80000000};
        vt[4] = '{"zeros",   0, 924,  3, 32'sd0,          32'sd0};

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_rst");

        // Single-sample frames on the FRAME_LEN=1 instance
        for (int c = 0; c < 2; c++) begin
            logic signed [7:0] sv;
            int b;
            int seen;
            b = (c == 0) ? 7 : 2;
            sv = sram[b];
            if (c == 0) begin s_base0 = 4'(b); s_req0 = 1'b1; end
            else        begin s_base1 = 4'(b); s_req1 = 1'b1; end
            seen = 0;
            for (int k = 0; k < 4 && seen == 0; k++) begin
                @(negedge clk);
                if (s_ack0 === 1'b1 || s_ack1 === 1'b1) seen = 1;
            end
            check("s_ack_seen", seen, 1);
            check("s_ack_ch", s_ack1, c);
            check("s_rd_en_c0", s_rd_en, 1);
            check("s_addr_c0", s_addr, b);
            s_req0 = 1'b0; s_req1 = 1'b0;
            @(negedge clk);
            check("s_rd_en_c1", s_rd_en, 0);
            check("s_d_c1", s_d, 0);
            @(negedge clk);
            check("s_d_c2", s_d, 1);
            check("s_max", s_max, sv);
            check("s_min", s_min, sv);
            check("s_done_ch", s_done_ch, c);
            @(negedge clk);
            check("s_busy_c3", s_busy, 0);
            check("s_hold_max", s_max, sv);
        end

        // Table-driven single frames
        for (int v = 0; v < 5; v++) begin
            fill_bg();
            fill_frame(vt[v].base, vt[v].pat);
            push_exp(vt[v].ch, vt[v].mx, vt[v].mn);
            if (vt[v].ch == 1) begin base1 = AW'(vt[v].base); req1 = 1'b1; end
            else               begin base0 = AW'(vt[v].base); req0 = 1'b1; end
            wait_ack(vt[v].ch, 5, t0);
            watch_frame(vt[v].ch, vt[v].base);
            check({vt[v].name, "_held_max"}, out_max, vt[v].mx);
        end

        // Request while busy: req1 rises during a ch0 frame
        fill_bg();
        fill_frame(0, 0);
        fill_frame(300, 1);
        base0 = 0; base1 = 300;
        push_exp(0, 32'sd49, -32'sd50);
        req0 = 1'b1;
        wait_ack(0, 5, t0);
        push_exp(1, -32'sd7, -32'sd7);
        req1 = 1'b1;
        watch_frame(0, 0);
        wait_ack(1, 5, t1);
        check("busy_req_gap", t1 - t0, FL + 3);
        watch_frame(1, 300);

        // Simultaneous requests after reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_exp(0, 32'sd49, -32'sd50);
        push_exp(1, -32'sd7, -32'sd7);
        req0 = 1'b1; req1 = 1'b1;
        wait_ack(0, 5, t0);
        watch_frame(0, 0);
        wait_ack(1, 5, t1);
        check("tie_gap", t1 - t0, FL + 3);
        watch_frame(1, 300);
        push_exp(0, 32'sd49, -32'sd50);
        req0 = 1'b1; req1 = 1'b1;
        wait_ack(0, 5, t0);
        req1 = 1'b0;
        watch_frame(0, 0);

        // Reset during read 40 abandons the frame
        push_exp(1, -32'sd7, -32'sd7);
        req1 = 1'b1;
        wait_ack(1, 5, t0);
        watch_frame(1, 300);
        req0 = 1'b1;
        wait_ack(0, 5, t0);
        repeat (40) @(negedge clk);
        check("abort_addr40", mem_addr, 40);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        repeat (3) @(negedge clk);
        check_all_zero("rst_hold");
        push_exp(0, 32'sd49, -32'sd50);
        rst_n = 1'b1;
        wait_ack(0, 5, t0);
        watch_frame(0, 0);

        repeat (5) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
